// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/memory/writeback
// sequencing, datapath selects, write strobes and memory handshake.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 0,
    parameter int TMO_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_is_fetch,
    output logic       ir_we,
    output logic       mdr_we,
    output logic       pc_we,
    output logic [1:0] pc_sel,
    output logic [2:0] imm_sel,
    output logic       alu_a_sel,
    output logic       alu_b_sel,
    output logic       rf_we,
    output logic [1:0] wb_sel,
    output logic       illegal,
    output logic       bus_err,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] IMM_NONE = 3'd0;
    localparam logic [2:0] IMM_I    = 3'd1;
    localparam logic [2:0] IMM_S    = 3'd2;
    localparam logic [2:0] IMM_B    = 3'd3;
    localparam logic [2:0] IMM_U    = 3'd4;
    localparam logic [2:0] IMM_J    = 3'd5;

    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_IMM   = 2'd1;
    localparam logic [1:0] PC_ALU   = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MDR = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_IMM = 2'd3;

    state_t           r_state;
    state_t           w_next;
    logic [TMO_W-1:0] r_tmo;
    logic             r_illegal;
    logic             r_bus_err;

    logic       w_legal;
    logic       w_is_load;
    logic       w_is_store;
    logic [2:0] w_imm;
    logic       w_a;
    logic       w_b;
    logic [1:0] w_wb;
    logic       w_wait;
    logic       w_tmo_hit;
    logic       w_set_ill;
    logic       w_set_bus;
    logic       w_sel_on;

    // Classify the IR opcode/funct3 and pick the datapath selects for it
    always_comb begin
        w_legal    = 1'b1;
        w_imm      = IMM_NONE;
        w_a        = 1'b0;
        w_b        = 1'b0;
        w_wb       = WB_ALU;
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        case (opcode)
            OPC_OP: w_legal = 1'b1;
            OPC_OPIMM: begin
                w_imm = IMM_I;
                w_b   = 1'b1;
            end
            OPC_LOAD: begin
                w_imm     = IMM_I;
                w_b       = 1'b1;
                w_wb      = WB_MDR;
                w_is_load = 1'b1;
                w_legal   = !(funct3 == 3'b011 || funct3 == 3'b110 ||
                              funct3 == 3'b111);
            end
            OPC_STORE: begin
                w_imm      = IMM_S;
                w_b        = 1'b1;
                w_is_store = 1'b1;
                w_legal    = (funct3 < 3'b011);
            end
            OPC_BRANCH: begin
                w_imm   = IMM_B;
                w_legal = !(funct3 == 3'b010 || funct3 == 3'b011);
            end
            OPC_JAL: begin
                w_imm = IMM_J;
                w_wb  = WB_PC4;
            end
            OPC_JALR: begin
                w_imm   = IMM_I;
                w_b     = 1'b1;
                w_wb    = WB_PC4;
                w_legal = (funct3 == 3'b000);
            end
            OPC_LUI: begin
                w_imm = IMM_U;
                w_wb  = WB_IMM;
            end
            OPC_AUIPC: begin
                w_imm = IMM_U;
                w_a   = 1'b1;
                w_b   = 1'b1;
            end
            default: w_legal = 1'b0;
        endcase
    end

    assign w_wait = (r_state == S_FETCH || r_state == S_MEM) && !mem_ready;

    generate
        if (MEM_TIMEOUT > 0) begin : g_tmo
            localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);
            assign w_tmo_hit = w_wait && (r_tmo == TMO_LAST);
        end else begin : g_no_tmo
            assign w_tmo_hit = 1'b0;
        end
    endgenerate

    // Selects only follow the decoded instruction from DECODE through WB
    assign w_sel_on = w_legal && (r_state == S_DECODE || r_state == S_EXEC ||
                                  r_state == S_MEM || r_state == S_WB);

    // Next-state and all control outputs; everything is forced low in reset
    always_comb begin
        w_next       = r_state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_is_fetch = 1'b0;
        ir_we        = 1'b0;
        mdr_we       = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = PC_PLUS4;
        imm_sel      = IMM_NONE;
        alu_a_sel    = 1'b0;
        alu_b_sel    = 1'b0;
        rf_we        = 1'b0;
        wb_sel       = WB_ALU;
        w_set_ill    = 1'b0;
        w_set_bus    = 1'b0;
        if (!rst) begin
            if (w_sel_on) begin
                imm_sel   = w_imm;
                alu_a_sel = w_a;
                alu_b_sel = w_b;
                wb_sel    = w_wb;
            end
            case (r_state)
                S_FETCH: begin
                    mem_req      = 1'b1;
                    mem_is_fetch = 1'b1;
                    if (mem_ready) begin
                        ir_we  = 1'b1;
                        w_next = S_DECODE;
                    end else if (w_tmo_hit) begin
                        w_next    = S_TRAP;
                        w_set_bus = 1'b1;
                    end
                end
                S_DECODE: begin
                    if (w_legal) begin
                        w_next = S_EXEC;
                    end else begin
                        w_next    = S_TRAP;
                        w_set_ill = 1'b1;
                    end
                end
                S_EXEC: begin
                    case (opcode)
                        OPC_BRANCH: begin
                            pc_we  = 1'b1;
                            pc_sel = branch_taken ? PC_IMM : PC_PLUS4;
                            w_next = S_FETCH;
                        end
                        OPC_JAL: begin
                            rf_we  = 1'b1;
                            pc_we  = 1'b1;
                            pc_sel = PC_IMM;
                            w_next = S_FETCH;
                        end
                        OPC_JALR: begin
                            rf_we  = 1'b1;
                            pc_we  = 1'b1;
                            pc_sel = PC_ALU;
                            w_next = S_FETCH;
                        end
                        OPC_LOAD, OPC_STORE: w_next = S_MEM;
                        default: w_next = S_WB;
                    endcase
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    mem_we  = w_is_store;
                    if (mem_ready) begin
                        if (w_is_store) begin
                            pc_we  = 1'b1;
                            w_next = S_FETCH;
                        end else begin
                            mdr_we = w_is_load;
                            w_next = S_WB;
                        end
                    end else if (w_tmo_hit) begin
                        w_next    = S_TRAP;
                        w_set_bus = 1'b1;
                    end
                end
                S_WB: begin
                    rf_we  = 1'b1;
                    pc_we  = 1'b1;
                    w_next = S_FETCH;
                end
                S_TRAP: w_next = S_TRAP;
                default: w_next = S_FETCH;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_next;
    end

    // Wait counter: runs only while a request stalls in the same state
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                            r_tmo <= '0;
        else if (w_wait && w_next == r_state) r_tmo <= r_tmo + TMO_W'(1);
        else                                r_tmo <= '0;
    end

    // Sticky trap causes, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_illegal <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            r_illegal <= r_illegal | w_set_ill;
            r_bus_err <= r_bus_err | w_set_bus;
        end
    end

    assign illegal = r_illegal;
    assign bus_err = r_bus_err;
    assign state_o = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: per-instruction expected cycle traces
// built from the instruction table, plus timeout and reset scenarios.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       branch_taken;
    logic       mem_ready;

    logic       a_mem_req, a_mem_we, a_fetch, a_ir_we, a_mdr_we, a_pc_we;
    logic [1:0] a_pc_sel, a_wb_sel;
    logic [2:0] a_imm_sel, a_state;
    logic       a_asel, a_bsel, a_rf_we, a_illegal, a_bus_err;

    logic       t_mem_req, t_mem_we, t_fetch, t_ir_we, t_mdr_we, t_pc_we;
    logic [1:0] t_pc_sel, t_wb_sel;
    logic [2:0] t_imm_sel, t_state;
    logic       t_asel, t_bsel, t_rf_we, t_illegal, t_bus_err;

    multicycle_ctrl #(.MEM_TIMEOUT(0), .TMO_W(8)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
        .branch_taken(branch_taken), .mem_ready(mem_ready),
        .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_is_fetch(a_fetch),
        .ir_we(a_ir_we), .mdr_we(a_mdr_we), .pc_we(a_pc_we),
        .pc_sel(a_pc_sel), .imm_sel(a_imm_sel), .alu_a_sel(a_asel),
        .alu_b_sel(a_bsel), .rf_we(a_rf_we), .wb_sel(a_wb_sel),
        .illegal(a_illegal), .bus_err(a_bus_err), .state_o(a_state)
    );

    multicycle_ctrl #(.MEM_TIMEOUT(4), .TMO_W(8)) dut_t (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
        .branch_taken(branch_taken), .mem_ready(mem_ready),
        .mem_req(t_mem_req), .mem_we(t_mem_we), .mem_is_fetch(t_fetch),
        .ir_we(t_ir_we), .mdr_we(t_mdr_we), .pc_we(t_pc_we),
        .pc_sel(t_pc_sel), .imm_sel(t_imm_sel), .alu_a_sel(t_asel),
        .alu_b_sel(t_bsel), .rf_we(t_rf_we), .wb_sel(t_wb_sel),
        .illegal(t_illegal), .bus_err(t_bus_err), .state_o(t_state)
    );

    always #5 clk = ~clk;

    logic [20:0] obs;
    logic [20:0] tobs;
    assign obs = {a_state, a_mem_req, a_mem_we, a_fetch, a_ir_we, a_mdr_we,
                  a_pc_we, a_pc_sel, a_imm_sel, a_asel, a_bsel, a_rf_we,
                  a_wb_sel, a_illegal, a_bus_err};
    assign tobs = {t_state, t_mem_req, t_mem_we, t_fetch, t_ir_we, t_mdr_we,
                   t_pc_we, t_pc_sel, t_imm_sel, t_asel, t_bsel, t_rf_we,
                   t_wb_sel, t_illegal, t_bus_err};

    int total = 0;
    int bad   = 0;

    localparam logic [2:0] K_ALU  = 3'd0;
    localparam logic [2:0] K_LOAD = 3'd1;
    localparam logic [2:0] K_ST   = 3'd2;
    localparam logic [2:0] K_BR   = 3'd3;
    localparam logic [2:0] K_JAL  = 3'd4;
    localparam logic [2:0] K_JALR = 3'd5;

    localparam logic [6:0] O_OP    = 7'b0110011;
    localparam logic [6:0] O_OPIMM = 7'b0010011;
    localparam logic [6:0] O_LOAD  = 7'b0000011;
    localparam logic [6:0] O_STORE = 7'b0100011;
    localparam logic [6:0] O_BR    = 7'b1100011;
    localparam logic [6:0] O_JAL   = 7'b1101111;
    localparam logic [6:0] O_JALR  = 7'b1100111;
    localparam logic [6:0] O_LUI   = 7'b0110111;
    localparam logic [6:0] O_AUIPC = 7'b0010111;

    typedef struct packed {
        logic       legal;
        logic [2:0] imm;
        logic       a;
        logic       b;
        logic [1:0] wb;
        logic [2:0] kind;
    } info_t;

    typedef struct packed {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        rdy;
        logic        tkn;
        logic [20:0] exp;
    } cyc_t;

    cyc_t q[$];

    // Instruction table: imm codes I=1 S=2 B=3 U=4 J=5, wb alu/mdr/pc4/imm
    function automatic info_t classify(input logic [6:0] op, input logic [2:0] f3);
        info_t r;
        r = '0;
        r.legal = 1'b1;
        r.kind = K_ALU;
        case (op)
            O_OP: r.kind = K_ALU;
            O_OPIMM: begin r.imm = 3'd1; r.b = 1'b1; end
            O_LOAD: begin
                r.kind = K_LOAD; r.imm = 3'd1; r.b = 1'b1; r.wb = 2'd1;
                r.legal = !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
            end
            O_STORE: begin
                r.kind = K_ST; r.imm = 3'd2; r.b = 1'b1;
                r.legal = (f3 <= 3'd2);
            end
            O_BR: begin
                r.kind = K_BR; r.imm = 3'd3;
                r.legal = !(f3 == 3'd2 || f3 == 3'd3);
            end
            O_JAL: begin r.kind = K_JAL; r.imm = 3'd5; r.wb = 2'd2; end
            O_JALR: begin
                r.kind = K_JALR; r.imm = 3'd1; r.b = 1'b1; r.wb = 2'd2;
                r.legal = (f3 == 3'd0);
            end
            O_LUI: begin r.imm = 3'd4; r.wb = 2'd3; end
            O_AUIPC: begin r.imm = 3'd4; r.a = 1'b1; r.b = 1'b1; end
            default: r.legal = 1'b0;
        endcase
        if (!r.legal) begin
            r.imm = 3'd0; r.a = 1'b0; r.b = 1'b0; r.wb = 2'd0;
        end
        return r;
    endfunction

    function automatic logic [20:0] mk(
        input int st, input int req, input int we, input int fe,
        input int ir, input int mdr, input int pcw, input int ps,
        input int imm, input int a, input int b, input int rf,
        input int wb, input int ill, input int be);
        return {3'(st), 1'(req), 1'(we), 1'(fe), 1'(ir), 1'(mdr), 1'(pcw),
                2'(ps), 3'(imm), 1'(a), 1'(b), 1'(rf), 2'(wb), 1'(ill), 1'(be)};
    endfunction

    // Append the expected cycles of one instruction (df/dm = wait cycles)
    task automatic push_instr(input logic [6:0] op, input logic [2:0] f3,
                              input logic tk, input int df, input int dm);
        info_t n;
        cyc_t  c;
        int    ld;
        int    st;
        n = classify(op, f3);
        ld = int'(n.kind == K_LOAD);
        st = int'(n.kind == K_ST);
        c.op = op;
        c.f3 = f3;
        for (int k = 0; k <= df; k++) begin
            c.rdy = (k == df);
            c.tkn = 1'($urandom);
            c.exp = mk(0, 1, 0, 1, int'(c.rdy), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            q.push_back(c);
        end
        c.rdy = 1'($urandom);
        c.tkn = 1'($urandom);
        c.exp = mk(1, 0, 0, 0, 0, 0, 0, 0, int'(n.imm), int'(n.a), int'(n.b),
                   0, int'(n.wb), 0, 0);
        q.push_back(c);
        if (!n.legal) return;
        c.rdy = 1'($urandom);
        c.tkn = tk;
        case (n.kind)
            K_BR: c.exp = mk(2, 0, 0, 0, 0, 0, 1, int'(tk), int'(n.imm),
                             int'(n.a), int'(n.b), 0, int'(n.wb), 0, 0);
            K_JAL: c.exp = mk(2, 0, 0, 0, 0, 0, 1, 1, int'(n.imm),
                              int'(n.a), int'(n.b), 1, int'(n.wb), 0, 0);
            K_JALR: c.exp = mk(2, 0, 0, 0, 0, 0, 1, 2, int'(n.imm),
                               int'(n.a), int'(n.b), 1, int'(n.wb), 0, 0);
            default: c.exp = mk(2, 0, 0, 0, 0, 0, 0, 0, int'(n.imm),
                                int'(n.a), int'(n.b), 0, int'(n.wb), 0, 0);
        endcase
        q.push_back(c);
        if (ld == 1 || st == 1) begin
            for (int k = 0; k <= dm; k++) begin
                c.rdy = (k == dm);
                c.tkn = 1'($urandom);
                c.exp = mk(3, 1, st, 0, 0, ld * int'(c.rdy), st * int'(c.rdy),
                           0, int'(n.imm), int'(n.a), int'(n.b), 0,
                           int'(n.wb), 0, 0);
                q.push_back(c);
            end
        end
        if (n.kind == K_ALU || n.kind == K_LOAD) begin
            c.rdy = 1'($urandom);
            c.tkn = 1'($urandom);
            c.exp = mk(4, 0, 0, 0, 0, 0, 1, 0, int'(n.imm), int'(n.a),
                       int'(n.b), 1, int'(n.wb), 0, 0);
            q.push_back(c);
        end
    endtask

    task automatic push_trap(input logic [6:0] op, input logic [2:0] f3, input int n);
        cyc_t c;
        c.op = op;
        c.f3 = f3;
        for (int k = 0; k < n; k++) begin
            c.rdy = 1'($urandom);
            c.tkn = 1'($urandom);
            c.exp = mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            q.push_back(c);
        end
    endtask

    // Drive each queued cycle at a falling edge and compare before the rise
    task automatic play(input string tag);
        cyc_t c;
        int   n;
        n = 0;
        while (q.size() != 0) begin
            c = q.pop_front();
            opcode = c.op;
            funct3 = c.f3;
            mem_ready = c.rdy;
            branch_taken = c.tkn;
            #1;
            total++;
            if (obs !== c.exp) begin
                bad++;
                $display("FAIL %s cyc%0d got=%h want=%h", tag, n, obs, c.exp);
            end
            n++;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b0;
        branch_taken = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        opcode = O_OPIMM;
        funct3 = 3'd0;
        mem_ready = 1'b1;
        branch_taken = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (obs !== 21'd0) begin
            bad++;
            $display("FAIL reset_a got=%h want=%h", obs, 21'd0);
        end
        total++;
        if (tobs !== 21'd0) begin
            bad++;
            $display("FAIL reset_t got=%h want=%h", tobs, 21'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (obs !== mk(0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)) begin
            bad++;
            $display("FAIL reset_release got=%h want=%h", obs,
                     mk(0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        @(negedge clk);
    endtask

    task automatic test_directed();
        do_reset();
        push_instr(O_OPIMM, 3'd0, 1'b0, 0, 0);
        play("addi");
        push_instr(O_LOAD, 3'd2, 1'b0, 0, 3);
        play("lw_wait3");
        push_instr(O_BR, 3'd0, 1'b1, 0, 0);
        play("beq_taken");
        push_instr(O_BR, 3'd0, 1'b0, 1, 0);
        play("beq_not");
        push_instr(O_STORE, 3'd2, 1'b0, 2, 1);
        play("sw");
        push_instr(O_JAL, 3'd5, 1'b1, 0, 0);
        play("jal");
        push_instr(O_JALR, 3'd0, 1'b0, 0, 0);
        play("jalr");
        push_instr(O_LUI, 3'd7, 1'b0, 0, 0);
        play("lui");
        push_instr(O_AUIPC, 3'd3, 1'b1, 0, 0);
        play("auipc");
        push_instr(O_OP, 3'd4, 1'b0, 0, 0);
        play("op");
    endtask

    task automatic test_illegal();
        do_reset();
        push_instr(O_JALR, 3'd1, 1'b0, 0, 0);
        push_trap(O_JALR, 3'd1, 10);
        play("jalr_f3");
        do_reset();
        push_instr(7'h7F, 3'd0, 1'b0, 1, 0);
        push_trap(7'h7F, 3'd0, 10);
        play("opc7f");
        do_reset();
        push_instr(O_STORE, 3'd3, 1'b0, 0, 0);
        push_trap(O_STORE, 3'd3, 3);
        play("sd_f3");
    endtask

    task automatic test_timeout();
        do_reset();
        opcode = O_OPIMM;
        funct3 = 3'd0;
        for (int k = 0; k < 4; k++) begin
            #1;
            total++;
            if (t_mem_req !== 1'b1 || t_state !== 3'd0) begin
                bad++;
                $display("FAIL tmo_wait%0d got req=%b st=%0d want req=1 st=0",
                         k, t_mem_req, t_state);
            end
            @(negedge clk);
        end
        for (int k = 0; k < 6; k++) begin
            mem_ready = (k == 5);
            #1;
            total++;
            if (tobs !== mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)) begin
                bad++;
                $display("FAIL tmo_trap%0d got=%h want=%h", k, tobs,
                         mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
            end
            total++;
            if (a_state !== 3'd0 || a_mem_req !== 1'b1 || a_bus_err !== 1'b0) begin
                bad++;
                $display("FAIL notmo_wait%0d got st=%0d req=%b be=%b want 0 1 0",
                         k, a_state, a_mem_req, a_bus_err);
            end
            @(negedge clk);
        end
        do_reset();
        for (int k = 0; k < 4; k++) begin
            mem_ready = (k == 3);
            #1;
            total++;
            if (t_mem_req !== 1'b1 || t_ir_we !== mem_ready) begin
                bad++;
                $display("FAIL tmo_late%0d got req=%b ir=%b want req=1 ir=%b",
                         k, t_mem_req, t_ir_we, mem_ready);
            end
            @(negedge clk);
        end
        mem_ready = 1'b0;
        #1;
        total++;
        if (t_state !== 3'd1 || t_bus_err !== 1'b0) begin
            bad++;
            $display("FAIL tmo_ready_wins got st=%0d be=%b want st=1 be=0",
                     t_state, t_bus_err);
        end
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        do_reset();
        push_instr(O_STORE, 3'd2, 1'b0, 0, 2);
        void'(q.pop_back());
        play("sw_pre");
        rst = 1'b1;
        mem_ready = 1'b1;
        #1;
        total++;
        if (obs !== 21'd0) begin
            bad++;
            $display("FAIL midrst_drop got=%h want=%h", obs, 21'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        mem_ready = 1'b0;
        #1;
        total++;
        if (obs !== mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)) begin
            bad++;
            $display("FAIL midrst_release got=%h want=%h", obs,
                     mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [6:0] ops[9];
        logic [6:0] op;
        logic [2:0] f3;
        info_t      n;
        ops = '{O_OP, O_OPIMM, O_LOAD, O_STORE, O_BR, O_JAL, O_JALR,
                O_LUI, O_AUIPC};
        do_reset();
        for (int i = 0; i < 60; i++) begin
            op = ops[$urandom_range(0, 8)];
            do begin
                f3 = 3'($urandom_range(0, 7));
                n = classify(op, f3);
            end while (!n.legal);
            push_instr(op, f3, 1'($urandom), $urandom_range(0, 5),
                       $urandom_range(0, 5));
            play($sformatf("rnd%0d", i));
        end
    endtask

    initial begin
        rst = 1'b1;
        opcode = 7'd0;
        funct3 = 3'd0;
        mem_ready = 1'b0;
        branch_taken = 1'b0;
        test_reset();
        test_directed();
        test_illegal();
        test_timeout();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
